chick_turn_ctrl: RTL
====================

# chick_turn_ctrl

Turn sequencer for the Chicken Cha-Cha-Cha game on the FPGA board. Owns the game state: player positions, current player, per-turn revealed-card mask, turn timeout and winner. Sits between the keypad decoder and the card/track face memory. Issues card-reveal requests, compares the revealed face with the track tile ahead, moves chicks and hands turns round-robin. Drives the display and LED logic through its status outputs.

## Interface

Parameters:
- NUM_PLAYERS, 4: players, legal 2..4.
- TRACK_LEN, 16: track tiles, power of two, ≥ 2·NUM_PLAYERS.
- TIMEOUT_CYC, 500_000_000: idle cycles in SELECT before the turn is forfeited.

Ports (TW = $clog2(TRACK_LEN), PW = $clog2(NUM_PLAYERS)):
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  start/restart button, level; rising edge used.
- key  in  4  debounced keypad code; 4'hF = no key; 0..14 = card index.
- card_req  out  1  card reveal request, held until acknowledged.
- card_idx  out  4  card being revealed, stable while card_req=1.
- card_ack  in  1  face valid this cycle.
- card_face  in  4  face of the revealed card, sampled with card_ack.
- track_idx  out  TW  tile the current player would land on.
- track_face  in  4  face of tile track_idx, combinational from track ROM.
- hide  out  1  one-cycle pulse: turn all cards face down.
- cur_player  out  PW  player whose turn it is.
- pos  out  NUM_PLAYERS·TW  packed positions, player p at [p·TW +: TW].
- win  out  1  game over, held.
- winner  out  PW  winning player, valid while win=1.
- state  out  3  encoded FSM state for display.

## Operation

- States: IDLE(0), SELECT(1), REQ(2), CMP(3), MOVE(4), PASS(5), RELEASE(6), WIN(7).
- IDLE: pos[p] = p·(TRACK_LEN/NUM_PLAYERS); steps[p]=0; cur_player=0; mask=0. start rising edge → SELECT.
- SELECT: timer counts up.
  - key ≠ F and mask[key]=0 → latch card_idx=key, set mask[key], clear timer → REQ.
  - key already in mask → ignored.
  - timer = TIMEOUT_CYC−1 → PASS.
  - mask[14:0] all set → PASS.
- REQ: card_req=1. On card_ack, latch card_face → CMP.
- CMP: target = first tile after pos[cur] (mod TRACK_LEN) not occupied by another player. At most NUM_PLAYERS−1 skips. track_idx = target.
  - card_face == track_face → MOVE.
  - Otherwise → PASS.
- MOVE: pos[cur] ← target; steps[cur] += forward distance, saturating at TRACK_LEN.
  - steps reaches TRACK_LEN → WIN, winner=cur.
  - Otherwise → RELEASE. Same player continues; mask kept.
- PASS: hide=1 for this cycle; mask ← 0; timer ← 0; cur ← (cur+1) mod NUM_PLAYERS → RELEASE.
- RELEASE: wait key == F → SELECT. Prevents a held key from being taken twice.
- WIN: win=1; positions frozen; start rising edge → IDLE.
- Position arithmetic wraps modulo TRACK_LEN. Distance = (target − pos) mod TRACK_LEN, 1..NUM_PLAYERS.

## Timing

- Reset (rst=0, async) values:
  - state=IDLE, card_req=0, card_idx=0, hide=0, win=0, winner=0, cur_player=0.
  - pos = start layout; track_idx=0; mask, steps, timer = 0.
  - Reset mid-turn aborts any pending request without waiting for card_ack.
- Key to request: key valid in SELECT at edge n → card_req=1 from cycle n+1.
- card_ack may arrive in the first REQ cycle or later. card_req drops the cycle after ack is sampled.
- card_ack outside REQ is ignored.
- CMP and MOVE take one cycle each. pos updates at the MOVE edge.
- Match to next SELECT: 2 cycles plus key release.
- hide is exactly one cycle per PASS.
- Timeout and valid key on the same SELECT cycle → key wins.
- start edge outside IDLE/WIN is ignored.

## Structure

- Shared package chick_pkg:
  - state encoding enum;
  - KEY_NONE = 4'hF;
  - NUM_CARDS = 15.
- Sub-module chick_target_finder: combinational next-unoccupied-tile search.
  - Inputs: pos vector, cur_player.
  - Outputs: target, distance.
- Remaining logic in chick_turn_ctrl: FSM, timer, mask, step counters.

## Test plan

- Reset, then start pulse → state=1, pos={12,8,4,0}, cur_player=0, all outputs otherwise zero.
- P0 presses key 3; ack after 2 cycles with face=track_face at tile 1 → pos[0]=1, same player. Key 3 is re-ignored until PASS.
- P0 key 5, face mismatch → one-cycle hide, cur_player=1, mask cleared. Held key 5 is not re-accepted until released.
- P1 at tile 3, P2 at tile 4, P3 at 5. Match → P1 lands on tile 6 (distance 3); steps[1] += 3.
- No key for TIMEOUT_CYC (set 20) cycles → PASS at cycle 20; cur_player advances.
- steps[2]=15, match → win=1, winner=2, state=7.
  - Further keys are ignored.
  - start edge → IDLE.
  - rst low during REQ → card_req=0 immediately.

Source files
------------

// File: rtl/chick_pkg.sv
// Shared types and constants for the Chicken Cha-Cha-Cha turn sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chick_pkg;

  // Encoding is visible on the display port, so values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_REQ     = 3'd2,
    ST_CMP     = 3'd3,
    ST_MOVE    = 3'd4,
    ST_PASS    = 3'd5,
    ST_RELEASE = 3'd6,
    ST_WIN     = 3'd7
  } state_e;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam int         NUM_CARDS = 15;

  // Starting tile of player p: chicks are spread evenly round the track.
  function automatic int home_tile(input int p, input int num_players, input int track_len);
    return p * (track_len / num_players);
  endfunction

endpackage

// File: rtl/chick_target_finder.sv
// Finds the first tile ahead of the current chick not held by another chick.
// Latency: purely combinational.
// Backpressure: none; output follows the position vector every cycle.
module chick_target_finder #(
  parameter  int NUM_PLAYERS = 4,
  parameter  int TRACK_LEN   = 16,
  localparam int TW          = $clog2(TRACK_LEN),
  localparam int PW          = $clog2(NUM_PLAYERS),
  localparam int DW          = $clog2(NUM_PLAYERS + 1)
) (
  input  logic [NUM_PLAYERS*TW-1:0] pos,
  input  logic [PW-1:0]             cur_player,
  output logic [TW-1:0]             target,
  output logic [DW-1:0]             distance
);

  logic [TW-1:0] cur_pos;
  logic [TW-1:0] cand;
  logic          occupied;
  logic          found;

  // Walk forward one tile at a time; at most NUM_PLAYERS-1 tiles can be blocked.
  always_comb begin
    cur_pos  = pos[int'(cur_player)*TW +: TW];
    target   = cur_pos + TW'(1);
    distance = DW'(1);
    cand     = '0;
    occupied = 1'b0;
    found    = 1'b0;
    for (int d = 1; d <= NUM_PLAYERS; d++) begin
      cand     = cur_pos + TW'(d);
      occupied = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if ((PW'(p) != cur_player) && (pos[p*TW +: TW] == cand)) occupied = 1'b1;
      end
      if (!found && !occupied) begin
        target   = cand;
        distance = DW'(d);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chick_turn_ctrl.sv
// Turn sequencer: card reveal, tile compare, chick moves, round-robin turns, winner.
// Latency: key to card_req 1 cycle; ack to CMP 1 cycle; CMP and MOVE 1 cycle each.
// Backpressure: card_req is held in REQ until card_ack; RELEASE stalls until the key is let go.
module chick_turn_ctrl
  import chick_pkg::*;
#(
  parameter  int NUM_PLAYERS = 4,
  parameter  int TRACK_LEN   = 16,
  parameter  int TIMEOUT_CYC = 500_000_000,
  localparam int TW          = $clog2(TRACK_LEN),
  localparam int PW          = $clog2(NUM_PLAYERS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                key,
  output logic                      card_req,
  output logic [3:0]                card_idx,
  input  logic                      card_ack,
  input  logic [3:0]                card_face,
  output logic [TW-1:0]             track_idx,
  input  logic [3:0]                track_face,
  output logic                      hide,
  output logic [PW-1:0]             cur_player,
  output logic [NUM_PLAYERS*TW-1:0] pos,
  output logic                      win,
  output logic [PW-1:0]             winner,
  output logic [2:0]                state
);

  localparam int DW  = $clog2(NUM_PLAYERS + 1);
  localparam int TMW = $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q, state_d;
  logic [TW-1:0]          pos_q   [NUM_PLAYERS];
  logic [TW-1:0]          pos_d   [NUM_PLAYERS];
  logic [TW:0]            steps_q [NUM_PLAYERS];
  logic [TW:0]            steps_d [NUM_PLAYERS];
  logic [PW-1:0]          cur_q, cur_d, winner_q, winner_d;
  logic [NUM_CARDS-1:0]   mask_q, mask_d;
  logic [TMW-1:0]         timer_q, timer_d;
  logic [3:0]             card_idx_q, card_idx_d, face_q, face_d;
  logic [TW-1:0]          track_idx_q, track_idx_d;
  logic [DW-1:0]          dist_q, dist_d;
  logic                   start_q, start_d;
  logic                   start_rise;
  logic [TW+1:0]          step_sum;
  logic [TW-1:0]          fnd_target;
  logic [DW-1:0]          fnd_dist;

  // Flatten positions for the output port and the finder.
  always_comb begin
    pos = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) pos[p*TW +: TW] = pos_q[p];
  end

  chick_target_finder #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .TRACK_LEN   (TRACK_LEN)
  ) u_finder (
    .pos        (pos),
    .cur_player (cur_q),
    .target     (fnd_target),
    .distance   (fnd_dist)
  );

  // Next-state and datapath updates for the turn FSM.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    steps_d     = steps_q;
    cur_d       = cur_q;
    winner_d    = winner_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    card_idx_d  = card_idx_q;
    face_d      = face_q;
    track_idx_d = track_idx_q;
    dist_d      = dist_q;
    start_d     = start;
    start_rise  = start & ~start_q;
    step_sum    = {1'b0, steps_q[cur_q]} + (TW+2)'(dist_q);

    unique case (state_q)
      ST_IDLE: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          pos_d[p]   = TW'(home_tile(p, NUM_PLAYERS, TRACK_LEN));
          steps_d[p] = '0;
        end
        cur_d    = '0;
        winner_d = '0;
        mask_d   = '0;
        timer_d  = '0;
        if (start_rise) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        timer_d = timer_q + TMW'(1);
        // A fresh key beats a timeout expiring on the same cycle.
        if ((key != KEY_NONE) && !mask_q[key]) begin
          card_idx_d  = key;
          mask_d[key] = 1'b1;
          timer_d     = '0;
          state_d     = ST_REQ;
        end else if ((timer_q == TMW'(TIMEOUT_CYC - 1)) || (&mask_q)) begin
          state_d = ST_PASS;
        end
      end
      ST_REQ: begin
        // Positions are stable until MOVE, so the target can be captured here.
        if (card_ack) begin
          face_d      = card_face;
          track_idx_d = fnd_target;
          dist_d      = fnd_dist;
          state_d     = ST_CMP;
        end
      end
      ST_CMP: begin
        state_d = (face_q == track_face) ? ST_MOVE : ST_PASS;
      end
      ST_MOVE: begin
        pos_d[cur_q] = track_idx_q;
        if (step_sum >= (TW+2)'(TRACK_LEN)) begin
          steps_d[cur_q] = (TW+1)'(TRACK_LEN);
          winner_d       = cur_q;
          state_d        = ST_WIN;
        end else begin
          steps_d[cur_q] = step_sum[TW:0];
          state_d        = ST_RELEASE;
        end
      end
      ST_PASS: begin
        mask_d  = '0;
        timer_d = '0;
        cur_d   = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + PW'(1);
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (key == KEY_NONE) state_d = ST_SELECT;
      end
      ST_WIN: begin
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any pending request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        pos_q[p]   <= TW'(home_tile(p, NUM_PLAYERS, TRACK_LEN));
        steps_q[p] <= '0;
      end
      cur_q       <= '0;
      winner_q    <= '0;
      mask_q      <= '0;
      timer_q     <= '0;
      card_idx_q  <= '0;
      face_q      <= '0;
      track_idx_q <= '0;
      dist_q      <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      steps_q     <= steps_d;
      cur_q       <= cur_d;
      winner_q    <= winner_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      card_idx_q  <= card_idx_d;
      face_q      <= face_d;
      track_idx_q <= track_idx_d;
      dist_q      <= dist_d;
      start_q     <= start_d;
    end
  end

  assign card_req   = (state_q == ST_REQ);
  assign hide       = (state_q == ST_PASS);
  assign win        = (state_q == ST_WIN);
  assign card_idx   = card_idx_q;
  assign track_idx  = track_idx_q;
  assign cur_player = cur_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule
